// File: rtl/oclib_uart_hex_decoder_if.sv
// Byte-in / word-out stream bundle for oclib_uart_hex_decoder.
// The slave modport is the decoder's view: it consumes bytes and produces words.
// The master modport is the view of whatever feeds bytes in and takes words out.
interface oclib_uart_hex_decoder_if #(
  parameter int Width       = 32,
  parameter int MaxDigits   = Width / 4,
  parameter int DigitCountW = $clog2(MaxDigits + 1)
);
  logic [7:0]             inData;
  logic                   inValid;
  logic                   inReady;
  logic [Width-1:0]       outData;
  logic [DigitCountW-1:0] outDigits;
  logic                   outValid;
  logic                   outReady;

  modport slave (
    input  inData, inValid, outReady,
    output inReady, outData, outDigits, outValid
  );

  modport master (
    output inData, inValid, outReady,
    input  inReady, outData, outDigits, outValid
  );
endinterface

// File: rtl/oclib_uart_hex_decoder.sv
// oclib_uart_hex_decoder: parses ASCII hex text from the UART RX stage into
// binary words, one word per terminator-delimited token.
// Optional feature macro: OCLIB_UART_HEX_ECHO_EN adds a byte echo stream
// (echoData/echoValid/echoReady) for driving a UART TX stage.
module oclib_uart_hex_decoder #(
  parameter int Width       = 32,
  parameter int MaxDigits   = Width / 4,
  parameter int ErrorWidth  = 2,
  parameter int DigitCountW = $clog2(MaxDigits + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clearError,
  output logic [ErrorWidth-1:0] error,
`ifdef OCLIB_UART_HEX_ECHO_EN
  output logic [7:0]            echoData,
  output logic                  echoValid,
  input  logic                  echoReady,
`endif
  oclib_uart_hex_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StSkip,
    StOut
  } state_t;

  typedef enum logic [2:0] {
    ClsDigit,
    ClsTerm,
    ClsBs,
    ClsEsc,
    ClsOther
  } char_class_t;

  localparam logic [DigitCountW-1:0] MaxCount = DigitCountW'(MaxDigits);

  state_t                 state;
  logic [Width-1:0]       acc;
  logic [DigitCountW-1:0] count;
  logic [Width-1:0]       out_data;
  logic [DigitCountW-1:0] out_digits;
  logic                   out_valid;
  logic [ErrorWidth-1:0]  err_set;
  char_class_t            cls;
  logic [3:0]             nibble;
  logic                   state_ready;
  logic                   in_ready;
  logic                   accept;

  // Classify the incoming byte and derive its nibble value (case-insensitive).
  always_comb begin
    cls    = ClsOther;
    nibble = 4'h0;
    if (bus.inData >= 8'h30 && bus.inData <= 8'h39) begin
      cls    = ClsDigit;
      nibble = 4'(bus.inData - 8'h30);
    end else if (bus.inData >= 8'h41 && bus.inData <= 8'h46) begin
      cls    = ClsDigit;
      nibble = 4'(bus.inData - 8'h37);
    end else if (bus.inData >= 8'h61 && bus.inData <= 8'h66) begin
      cls    = ClsDigit;
      nibble = 4'(bus.inData - 8'h57);
    end else begin
      case (bus.inData)
        8'h0A, 8'h0D, 8'h20, 8'h09: cls = ClsTerm;
        8'h08, 8'h7F:               cls = ClsBs;
        8'h1B:                      cls = ClsEsc;
        default:                    cls = ClsOther;
      endcase
    end
  end

  // Ready follows the state, is held low during reset, and waits on echo space.
  always_comb begin
    state_ready = (state != StOut);
`ifdef OCLIB_UART_HEX_ECHO_EN
    in_ready = reset && state_ready && (!echoValid || echoReady);
`else
    in_ready = reset && state_ready;
`endif
    accept = bus.inValid && in_ready;
  end

  // Work out which error bits this cycle's accepted byte sets.
  always_comb begin
    err_set = '0;
    if (accept) begin
      case (state)
        StIdle: begin
          if (cls == ClsOther) err_set[1] = 1'b1;
        end
        StAccum: begin
          if (cls == ClsDigit && count == MaxCount) err_set[0] = 1'b1;
          if (cls == ClsOther)                      err_set[1] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Parser FSM: accumulates digits, emits words on terminators, skips bad lines.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= StIdle;
      acc        <= '0;
      count      <= '0;
      out_data   <= '0;
      out_digits <= '0;
      out_valid  <= 1'b0;
      error      <= '0;
    end else begin
      error <= (clearError ? '0 : error) | err_set;
      case (state)
        StIdle: begin
          if (accept) begin
            if (cls == ClsDigit) begin
              acc   <= Width'(nibble);
              count <= DigitCountW'(1);
              state <= StAccum;
            end else if (cls == ClsOther) begin
              state <= StSkip;
            end
          end
        end
        StAccum: begin
          if (accept) begin
            case (cls)
              ClsDigit: begin
                if (count == MaxCount) begin
                  acc   <= '0;
                  count <= '0;
                  state <= StSkip;
                end else begin
                  acc   <= (acc << 4) | Width'(nibble);
                  count <= count + DigitCountW'(1);
                end
              end
              ClsTerm: begin
                out_data   <= acc;
                out_digits <= count;
                out_valid  <= 1'b1;
                state      <= StOut;
              end
              ClsBs: begin
                acc   <= acc >> 4;
                count <= count - DigitCountW'(1);
                if (count == DigitCountW'(1)) state <= StIdle;
              end
              ClsEsc: begin
                acc   <= '0;
                count <= '0;
                state <= StIdle;
              end
              default: begin
                acc   <= '0;
                count <= '0;
                state <= StSkip;
              end
            endcase
          end
        end
        StSkip: begin
          if (accept && (cls == ClsTerm || cls == ClsEsc)) begin
            acc   <= '0;
            count <= '0;
            state <= StIdle;
          end
        end
        StOut: begin
          if (bus.outReady) begin
            out_valid <= 1'b0;
            acc       <= '0;
            count     <= '0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifdef OCLIB_UART_HEX_ECHO_EN
  // Echo every accepted byte, holding it until the TX stage takes it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      echoData  <= 8'h00;
      echoValid <= 1'b0;
    end else if (accept) begin
      echoData  <= bus.inData;
      echoValid <= 1'b1;
    end else if (echoReady) begin
      echoValid <= 1'b0;
    end
  end
`endif

  assign bus.inReady   = in_ready;
  assign bus.outData   = out_data;
  assign bus.outDigits = out_digits;
  assign bus.outValid  = out_valid;

endmodule

// File: tb/tb_oclib_uart_hex_decoder.sv
// Directed testbench for oclib_uart_hex_decoder (default build, echo disabled).
module tb_oclib_uart_hex_decoder;

  localparam logic [7:0] Cr  = 8'h0D;
  localparam logic [7:0] Lf  = 8'h0A;
  localparam logic [7:0] Sp  = 8'h20;
  localparam logic [7:0] Bs  = 8'h08;
  localparam logic [7:0] Esc = 8'h1B;

  logic       clock;
  logic       reset;
  logic       clearError;
  logic [1:0] error;

  int checkCount;
  int errorCount;
  int wordTotal;
  int validCycles;
  logic [31:0] qData[$];
  logic [3:0]  qDigits[$];

  oclib_uart_hex_decoder_if #(.Width(32)) bus ();

  oclib_uart_hex_decoder dut (
    .clock     (clock),
    .reset     (reset),
    .clearError(clearError),
    .error     (error),
    .bus       (bus)
  );

  // Free-running clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Record every completed word handshake and count cycles with outValid high.
  always @(posedge clock) begin
    if (reset && bus.outValid && bus.outReady) begin
      qData.push_back(bus.outData);
      qDigits.push_back(bus.outDigits);
      wordTotal++;
    end
    if (reset && bus.outValid) validCycles++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present one byte starting at a falling edge; returns at the falling edge after acceptance.
  task automatic applyStimulus(input logic [7:0] b);
    int waitCycles;
    waitCycles = 0;
    bus.inData  = b;
    bus.inValid = 1'b1;
    while (!bus.inReady && waitCycles < 100) begin
      @(negedge clock);
      waitCycles++;
    end
    if (!bus.inReady) checkOutput("in_ready_timeout", 0, 1);
    @(posedge clock);
    @(negedge clock);
    bus.inValid = 1'b0;
  endtask

  task automatic sendString(input string s);
    for (int i = 0; i < s.len(); i++) applyStimulus(s[i]);
  endtask

  // Let a pending word drain, then compare the oldest recorded word.
  task automatic checkWord(input string tag, input logic [31:0] d, input logic [3:0] n);
    @(negedge clock);
    @(negedge clock);
    checkOutput({tag, "_present"}, 64'(qData.size() > 0), 1);
    if (qData.size() > 0) begin
      checkOutput({tag, "_data"}, qData.pop_front(), d);
      checkOutput({tag, "_digits"}, qDigits.pop_front(), n);
    end
  endtask

  task automatic pulseClear();
    clearError = 1'b1;
    @(negedge clock);
    clearError = 1'b0;
  endtask

  // Watchdog so a stuck DUT still ends the run.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int snap;
    int bad;
    checkCount  = 0;
    errorCount  = 0;
    wordTotal   = 0;
    validCycles = 0;
    reset       = 1'b0;
    clearError  = 1'b0;
    bus.inData  = 8'h00;
    bus.inValid = 1'b0;
    bus.outReady = 1'b1;

    // Reset state.
    repeat (3) @(negedge clock);
    checkOutput("rst_out_valid", bus.outValid, 0);
    checkOutput("rst_out_data", bus.outData, 0);
    checkOutput("rst_out_digits", bus.outDigits, 0);
    checkOutput("rst_error", error, 0);
    checkOutput("rst_in_ready", bus.inReady, 0);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("idle_in_ready", bus.inReady, 1);

    // Basic word with one-cycle latency and single-cycle valid.
    sendString("1a2B");
    applyStimulus(Cr);
    checkOutput("t1_latency", bus.outValid, 1);
    checkWord("t1", 32'h0000_1A2B, 4'd4);
    checkOutput("t1_valid_cycles", validCycles, 1);
    checkOutput("t1_word_total", wordTotal, 1);
    checkOutput("t1_error", error, 0);

    // Terminators alone never form words.
    snap = wordTotal;
    applyStimulus(Cr); applyStimulus(Lf); applyStimulus(Sp);
    applyStimulus(Sp); applyStimulus(Cr); applyStimulus(Lf);
    repeat (2) @(negedge clock);
    checkOutput("t2_no_word", wordTotal, snap);
    checkOutput("t2_error", error, 0);
    checkOutput("t2_in_ready", bus.inReady, 1);

    // Digit overflow drops the word and stays sticky.
    snap = wordTotal;
    sendString("123456789");
    applyStimulus(Lf);
    repeat (2) @(negedge clock);
    checkOutput("t3_overflow_err", error, 2'b01);
    checkOutput("t3_no_word", wordTotal, snap);
    sendString("FF");
    applyStimulus(Lf);
    checkWord("t3_ff", 32'h0000_00FF, 4'd2);
    checkOutput("t3_sticky", error, 2'b01);
    pulseClear();
    checkOutput("t3_cleared", error, 2'b00);

    // Exactly MaxDigits digits is still a valid word.
    sendString("89ABCDEF");
    applyStimulus(Lf);
    checkWord("t3_full", 32'h89AB_CDEF, 4'd8);

    // Invalid character skips to the terminator, then parsing resumes.
    sendString("12G4 5");
    applyStimulus(Lf);
    checkWord("t4_five", 32'h0000_0005, 4'd1);
    checkOutput("t4_invalid_err", error, 2'b10);
    checkOutput("t4_queue_empty", qData.size(), 0);
    pulseClear();

    // Backspace removes the last digit.
    sendString("AB");
    applyStimulus(Bs);
    sendString("C");
    applyStimulus(Lf);
    checkWord("t4_bs", 32'h0000_00AC, 4'd2);

    // Escape abandons the word; backspace to empty returns to idle silently.
    snap = wordTotal;
    sendString("7");
    applyStimulus(Esc);
    applyStimulus(Lf);
    sendString("5");
    applyStimulus(Bs);
    applyStimulus(Lf);
    repeat (2) @(negedge clock);
    checkOutput("t4_esc_no_word", wordTotal, snap);
    checkOutput("t4_esc_error", error, 0);

    // Back-pressure: word held and input stalled until outReady.
    bus.outReady = 1'b0;
    sendString("CAFE");
    applyStimulus(Sp);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!(bus.outValid === 1'b1 && bus.inReady === 1'b0 &&
            bus.outData === 32'h0000_CAFE && bus.outDigits === 4'd4)) bad++;
      @(negedge clock);
    end
    checkOutput("t5_hold_bad_cycles", bad, 0);
    checkOutput("t5_data", bus.outData, 32'h0000_CAFE);
    checkOutput("t5_digits", bus.outDigits, 4);
    bus.outReady = 1'b1;
    @(negedge clock);
    checkOutput("t5_valid_dropped", bus.outValid, 0);
    checkOutput("t5_in_ready_back", bus.inReady, 1);
    checkOutput("t5_word_seen", qData.size(), 1);
    if (qData.size() > 0) begin
      checkOutput("t5_seen_data", qData.pop_front(), 32'h0000_CAFE);
      void'(qDigits.pop_front());
    end

    // Asynchronous reset mid-word clears everything, no residue afterwards.
    sendString("X");
    applyStimulus(Lf);
    checkOutput("t6_pre_error", error, 2'b10);
    sendString("AB");
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t6_async_error", error, 0);
    checkOutput("t6_async_valid", bus.outValid, 0);
    checkOutput("t6_async_in_ready", bus.inReady, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    sendString("C");
    applyStimulus(Lf);
    checkWord("t6_c", 32'h0000_000C, 4'd1);

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
